// File: rtl/gearbox_rx.sv
// Receive 20:67 gearbox for an Interlaken lane: reassembles serial-order beats into
// 67-bit words, finds sync-header alignment by bit slipping and reports block lock.
module gearbox_rx #(
  parameter int LOCK_GOOD_CNT = 64,
  parameter int LOCK_BAD_CNT  = 16,
  parameter int LOCK_WINDOW   = 64
) (
  input  logic        USER_CLK,
  input  logic        SYSTEM_RESET,
  input  logic [19:0] DATA_IN,
  input  logic        DATA_IN_VALID,
  output logic [66:0] DATA_OUT,
  output logic        DATA_OUT_VALID,
  output logic        SYNC_HDR_ERR,
  output logic        BLOCK_LOCK
);

  localparam int GOOD_W = $clog2(LOCK_GOOD_CNT + 1);
  localparam int BAD_W  = $clog2(LOCK_BAD_CNT + 1);
  localparam int WIN_W  = $clog2(LOCK_WINDOW + 1);

  typedef enum logic [0:0] {
    S_HUNT   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [GOOD_W-1:0]   good_q, good_d;
  logic [BAD_W-1:0]    bad_q, bad_d;
  logic [WIN_W-1:0]    win_q, win_d;
  logic                slip_q, slip_d;

  logic [87:0]         store_q, store_d;
  logic [6:0]          fill_q, fill_d;
  logic [66:0]         word_q, word_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                block_lock;

  logic [19:0]         rev;
  logic [87:0]         incoming;
  logic [87:0]         merged;
  logic [6:0]          fill_sum;
  logic [6:0]          need;
  logic                extract;
  logic                hdr_ok;
  logic [66:0]         word;

  // Oldest wire bit lands in the MSB so storage reads out oldest-first.
  genvar gi;
  generate
    for (gi = 0; gi < 20; gi++) begin : g_rev
      assign rev[19-gi] = DATA_IN[gi];
    end
  endgenerate

  // Storage keeps unused low bits at zero, so a new beat can be OR-ed in below the fill point.
  always_comb begin
    incoming = {rev, 68'd0} >> fill_q;
    merged   = store_q | incoming;
    fill_sum = fill_q + 7'd20;
    need     = slip_q ? 7'd68 : 7'd67;
    extract  = DATA_IN_VALID && (fill_sum >= need);
    word     = slip_q ? merged[86:20] : merged[87:21];
    hdr_ok   = word[65] ^ word[64];
  end

  always_comb begin
    store_d = store_q;
    fill_d  = fill_q;
    word_d  = word_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (DATA_IN_VALID) begin
      store_d = merged;
      fill_d  = fill_sum;
      if (extract) begin
        store_d = merged << need;
        fill_d  = fill_sum - need;
        word_d  = word;
        valid_d = 1'b1;
        err_d   = !hdr_ok;
      end
    end
  end

  always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
    if (SYSTEM_RESET) begin
      store_q <= '0;
      fill_q  <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      store_q <= store_d;
      fill_q  <= fill_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
    if (SYSTEM_RESET) begin
      state_q <= S_HUNT;
      good_q  <= '0;
      bad_q   <= '0;
      win_q   <= '0;
      slip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      win_q   <= win_d;
      slip_q  <= slip_d;
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    win_d   = win_q;
    slip_d  = slip_q;
    if (extract) begin
      slip_d = 1'b0;
      if (state_q == S_HUNT) begin
        if (!hdr_ok) begin
          good_d = '0;
          slip_d = 1'b1;
        end else if (good_q == GOOD_W'(LOCK_GOOD_CNT - 1)) begin
          state_d = S_LOCKED;
          good_d  = '0;
          bad_d   = '0;
          win_d   = '0;
        end else begin
          good_d = good_q + GOOD_W'(1);
        end
      end else begin
        // Loss of lock wins over the window-boundary clear when both land on one word.
        if (!hdr_ok && bad_q == BAD_W'(LOCK_BAD_CNT - 1)) begin
          state_d = S_HUNT;
          good_d  = '0;
          bad_d   = '0;
          win_d   = '0;
        end else if (win_q == WIN_W'(LOCK_WINDOW - 1)) begin
          bad_d = '0;
          win_d = '0;
        end else begin
          win_d = win_q + WIN_W'(1);
          if (!hdr_ok) begin
            bad_d = bad_q + BAD_W'(1);
          end
        end
      end
    end
  end

  always_comb begin
    block_lock = (state_q == S_LOCKED);
  end

  assign DATA_OUT       = word_q;
  assign DATA_OUT_VALID = valid_q;
  assign SYNC_HDR_ERR   = err_q;
  assign BLOCK_LOCK     = block_lock;

endmodule

// File: tb/tb_gearbox_rx.sv
// Directed bench for gearbox_rx: serialises known 67-bit words onto the 20-bit
// input and checks word order, beat timing, header errors, slipping and lock.
module tb_gearbox_rx;

  logic        USER_CLK;
  logic        SYSTEM_RESET;
  logic [19:0] DATA_IN;
  logic        DATA_IN_VALID;
  logic [66:0] DATA_OUT;
  logic        DATA_OUT_VALID;
  logic        SYNC_HDR_ERR;
  logic        BLOCK_LOCK;

  gearbox_rx dut (
    .USER_CLK      (USER_CLK),
    .SYSTEM_RESET  (SYSTEM_RESET),
    .DATA_IN       (DATA_IN),
    .DATA_IN_VALID (DATA_IN_VALID),
    .DATA_OUT      (DATA_OUT),
    .DATA_OUT_VALID(DATA_OUT_VALID),
    .SYNC_HDR_ERR  (SYNC_HDR_ERR),
    .BLOCK_LOCK    (BLOCK_LOCK)
  );

  initial USER_CLK = 1'b0;
  always #5 USER_CLK = ~USER_CLK;

  int          n_pass  = 0;
  int          n_total = 0;
  int          beat_no;
  int          idle_act;
  bit          q_bits[$];
  logic [66:0] outs[$];
  bit          errs[$];
  bit          locks[$];
  int          obeats[$];

  task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [66:0] mkword(input int n, input bit bad);
    logic [1:0]  h;
    logic [66:0] w;
    h = bad ? 2'b00 : (((n % 2) == 1) ? 2'b10 : 2'b01);
    w = {((n % 3) == 0), h, 32'hC0DE_0000 + 32'(n), 32'(n * 7 + 1)};
    return w;
  endfunction

  task automatic push_word(input logic [66:0] w);
    for (int k = 66; k >= 0; k--) q_bits.push_back(w[k]);
  endtask

  task automatic clear_logs();
    q_bits.delete();
    outs.delete();
    errs.delete();
    locks.delete();
    obeats.delete();
    beat_no  = 0;
    idle_act = 0;
  endtask

  task automatic pulse_reset();
    @(negedge USER_CLK);
    DATA_IN_VALID = 1'b0;
    SYSTEM_RESET  = 1'b1;
    @(negedge USER_CLK);
    SYSTEM_RESET  = 1'b0;
  endtask

  // Drives nvalid valid beats (pct% valid duty) and logs every output word.
  task automatic run(input int nvalid, input int pct);
    int          target;
    int          guard;
    logic [19:0] din;
    bit          v;
    bit          lock_prev;
    target = beat_no + nvalid;
    guard  = 0;
    while (beat_no < target && guard < nvalid * 20 + 100) begin
      guard++;
      v = ($urandom_range(99) < 32'(pct));
      lock_prev = BLOCK_LOCK;
      @(negedge USER_CLK);
      if (v) begin
        for (int i = 0; i < 20; i++) din[i] = (q_bits.size() > 0) ? q_bits.pop_front() : 1'b0;
        beat_no++;
      end else begin
        din = 20'($urandom);
      end
      DATA_IN       = din;
      DATA_IN_VALID = v;
      @(posedge USER_CLK);
      #1;
      if (!v && (DATA_OUT_VALID || BLOCK_LOCK != lock_prev)) idle_act++;
      if (DATA_OUT_VALID) begin
        outs.push_back(DATA_OUT);
        errs.push_back(SYNC_HDR_ERR);
        locks.push_back(BLOCK_LOCK);
        obeats.push_back(beat_no);
      end
    end
    chki("run_budget", beat_no, target);
    @(negedge USER_CLK);
    DATA_IN_VALID = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          e;
    int          cnt;
    int          cnt2;
    logic [66:0] a;
    logic [66:0] b;

    SYSTEM_RESET  = 1'b0;
    DATA_IN       = '0;
    DATA_IN_VALID = 1'b0;
    #2;
    SYSTEM_RESET = 1'b1;
    repeat (2) @(posedge USER_CLK);
    @(negedge USER_CLK);
    chk("rst_data_out", DATA_OUT, 67'd0);
    chki("rst_valid", int'(DATA_OUT_VALID), 0);
    chki("rst_err", int'(SYNC_HDR_ERR), 0);
    chki("rst_lock", int'(BLOCK_LOCK), 0);
    SYSTEM_RESET = 1'b0;

    // Aligned continuous stream.
    clear_logs();
    for (int n = 0; n < 83; n++) push_word(mkword(n, 1'b0));
    run(268, 100);
    chki("t2_count", outs.size(), 80);
    chki("t2_beat0", obeats[0], 4);
    chki("t2_beat1", obeats[1], 7);
    chki("t2_beat2", obeats[2], 11);
    chki("t2_beat3", obeats[3], 14);
    chki("t2_beat19", obeats[19], 67);
    chki("t2_beat20", obeats[20], 71);
    for (int i = 0; i < 80; i++) chk($sformatf("t2_word%0d", i), outs[i], mkword(i, 1'b0));
    cnt = 0;
    foreach (errs[i]) cnt += int'(errs[i]);
    chki("t2_err_count", cnt, 0);
    chki("t2_lock62", int'(locks[62]), 0);
    chki("t2_lock63", int'(locks[63]), 1);
    chki("t2_lock79", int'(locks[79]), 1);

    // Asynchronous reset mid-word while locked.
    run(3, 100);
    chki("t6_locked_before", int'(BLOCK_LOCK), 1);
    @(negedge USER_CLK);
    #2;
    SYSTEM_RESET = 1'b1;
    #1;
    chk("t6_async_data", DATA_OUT, 67'd0);
    chki("t6_async_valid", int'(DATA_OUT_VALID), 0);
    chki("t6_async_err", int'(SYNC_HDR_ERR), 0);
    chki("t6_async_lock", int'(BLOCK_LOCK), 0);
    @(negedge USER_CLK);
    SYSTEM_RESET = 1'b0;
    clear_logs();
    for (int n = 0; n < 5; n++) push_word(mkword(n, 1'b0));
    run(8, 100);
    chki("t6_beat0", obeats[0], 4);
    chki("t6_beat1", obeats[1], 7);
    chk("t6_word0", outs[0], mkword(0, 1'b0));
    chki("t6_lock0", int'(locks[0]), 0);

    // Five junk bits ahead of the aligned stream.
    pulse_reset();
    clear_logs();
    for (int k = 0; k < 5; k++) q_bits.push_back(1'b0);
    for (int n = 0; n < 95; n++) push_word(mkword(n, 1'b0));
    run(300, 100);
    e   = -1;
    cnt = 0;
    for (int i = 0; i < outs.size(); i++) if (errs[i]) begin e = i; cnt++; end
    chki("t3_err_count", cnt, 5);
    chki("t3_enough_words", int'(outs.size() > e + 70), 1);
    chki("t3_lock_before", int'(locks[e + 63]), 0);
    chki("t3_lock_at", int'(locks[e + 64]), 1);
    cnt2 = 0;
    for (int i = e + 64; i < outs.size(); i++) cnt2 += int'(locks[i]);
    chki("t3_lock_held", cnt2, outs.size() - (e + 64));
    for (int i = e + 1; i < outs.size(); i++) chk($sformatf("t3_word%0d", i), outs[i], mkword(i, 1'b0));

    // Header corruption while locked: 15 in one window, then 16 in the next.
    pulse_reset();
    clear_logs();
    for (int n = 0; n < 160; n++)
      push_word(mkword(n, (n >= 70 && n <= 84) || (n >= 130 && n <= 145) || n == 150));
    run(520, 100);
    chki("t4_err70", int'(errs[70]), 1);
    chki("t4_lock84", int'(locks[84]), 1);
    chki("t4_lock127", int'(locks[127]), 1);
    chki("t4_lock144", int'(locks[144]), 1);
    chki("t4_lock145", int'(locks[145]), 0);
    chki("t4_err145", int'(errs[145]), 1);
    chk("t4_word149", outs[149], mkword(149, 1'b0));
    chki("t4_err149", int'(errs[149]), 0);
    chki("t4_err150", int'(errs[150]), 1);
    a = mkword(151, 1'b0);
    b = mkword(152, 1'b0);
    chk("t4_slip151", outs[151], {a[65:0], b[66]});

    // Random valid gaps on the aligned stream.
    pulse_reset();
    clear_logs();
    for (int n = 0; n < 45; n++) push_word(mkword(n, 1'b0));
    run(134, 50);
    chki("t5_count", outs.size(), 40);
    chki("t5_idle_activity", idle_act, 0);
    chki("t5_beat0", obeats[0], 4);
    chki("t5_beat1", obeats[1], 7);
    chki("t5_beat19", obeats[19], 67);
    chki("t5_beat39", obeats[39], 134);
    for (int i = 0; i < 40; i++) chk($sformatf("t5_word%0d", i), outs[i], mkword(i, 1'b0));

    // All-zero input after reset.
    pulse_reset();
    clear_logs();
    run(300, 100);
    chki("t7_count", outs.size(), 88);
    cnt  = 0;
    cnt2 = 0;
    foreach (errs[i]) cnt += int'(errs[i]);
    foreach (locks[i]) cnt2 += int'(locks[i]);
    chki("t7_err_count", cnt, 88);
    chki("t7_lock_count", cnt2, 0);
    cnt = 0;
    foreach (outs[i]) if (outs[i] === 67'd0) cnt++;
    chki("t7_zero_words", cnt, 88);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
